// File: rtl/msx_audio_mixer_pkg.sv
// Shared types and constants for the time-multiplexed MSX audio mixer.
package msx_audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mixer_state_t;

  localparam int unsigned MIX_UNITY_GAIN = 128;

endpackage

// File: rtl/msx_audio_mixer_if.sv
// Sample-source side and mixed-output side of the audio mixer.
interface msx_audio_mixer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned GAIN_W   = 8,
  parameter int unsigned OUT_W    = 16
);

  logic                         ce_sample;
  logic [CHANNELS*IN_W-1:0]     ch_in;
  logic [CHANNELS*GAIN_W-1:0]   ch_gain;
  logic [CHANNELS-1:0]          ch_mute;
  logic                         stat_clr;
  logic [OUT_W-1:0]             audio;
  logic                         audio_valid;
  logic                         busy;
  logic                         clip;
  logic                         overrun;

  modport master (
    output ce_sample, ch_in, ch_gain, ch_mute, stat_clr,
    input  audio, audio_valid, busy, clip, overrun
  );

  modport slave (
    input  ce_sample, ch_in, ch_gain, ch_mute, stat_clr,
    output audio, audio_valid, busy, clip, overrun
  );

endinterface

// File: rtl/msx_audio_mixer_audio_sat.sv
// Combinational signed saturation from IN_W to OUT_W bits with a clip flag.
module audio_sat #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout_c,
  output logic             clip_c
);

  generate
    if (IN_W > OUT_W) begin : g_narrow
      // Value fits when every bit from the OUT_W sign position upward agrees.
      logic [IN_W-OUT_W:0] hi_c;

      always_comb begin
        hi_c   = din[IN_W-1:OUT_W-1];
        clip_c = !((hi_c == '0) || (&hi_c));
        dout_c = din[OUT_W-1:0];
        if (clip_c) begin
          dout_c = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_wide
      assign dout_c = OUT_W'($signed(din));
      assign clip_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/msx_audio_mixer.sv
// N-channel gain/mute mixer: snapshot on ce_sample, one MAC per clock, saturate.
module msx_audio_mixer
  import msx_audio_mixer_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = $clog2(MIX_UNITY_GAIN),
  parameter int unsigned OUT_W     = 16
) (
  input logic               clk21m,
  input logic               reset_n,
  msx_audio_mixer_if.slave  bus
);

  localparam int unsigned PROD_W = IN_W + GAIN_W + 1;
  localparam int unsigned CH_LOG = $clog2(CHANNELS);
  localparam int unsigned ACC_W  = PROD_W + CH_LOG + 1;
  localparam int unsigned SAT_W  = ACC_W - GAIN_FRAC;
  localparam int unsigned IDX_W  = (CHANNELS > 1) ? CH_LOG : 1;

  mixer_state_t             state;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic [OUT_W-1:0]         audio;
  logic                     audio_valid;
  logic                     busy;
  logic                     clip;
  logic                     overrun;

  logic signed [IN_W-1:0]   snap_in   [CHANNELS];
  logic [GAIN_W-1:0]        snap_gain [CHANNELS];
  logic [CHANNELS-1:0]      snap_mute;

  logic                     capture_c;
  logic signed [PROD_W-1:0] in_ext_c;
  logic signed [PROD_W-1:0] gain_ext_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [OUT_W-1:0]         sat_c;
  logic                     sat_clip_c;

  assign capture_c = (state == IDLE) && bus.ce_sample;

  // Contribution of the channel currently selected by idx.
  always_comb begin
    in_ext_c   = PROD_W'(snap_in[idx]);
    gain_ext_c = PROD_W'({1'b0, snap_gain[idx]});
    prod_c     = snap_mute[idx] ? '0 : (in_ext_c * gain_ext_c);
  end

  audio_sat #(
    .IN_W  (SAT_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din    (acc[ACC_W-1:GAIN_FRAC]),
    .dout_c (sat_c),
    .clip_c (sat_clip_c)
  );

  // Input snapshot so sources may change freely once a frame has started.
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        snap_in[k]   <= '0;
        snap_gain[k] <= '0;
      end
      snap_mute <= '0;
    end else if (capture_c) begin
      for (int k = 0; k < CHANNELS; k++) begin
        snap_in[k]   <= bus.ch_in[k*IN_W +: IN_W];
        snap_gain[k] <= bus.ch_gain[k*GAIN_W +: GAIN_W];
      end
      snap_mute <= bus.ch_mute;
    end
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      // Sticky flags: a new event in the same cycle as stat_clr wins.
      clip    <= (clip & ~bus.stat_clr) | ((state == SAT) & sat_clip_c);
      overrun <= (overrun & ~bus.stat_clr) | ((state != IDLE) & bus.ce_sample);

      case (state)
        IDLE: begin
          if (capture_c) begin
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + ACC_W'(prod_c);
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(CHANNELS - 1)) begin
            state <= SAT;
          end
        end
        SAT: begin
          audio       <= sat_c;
          audio_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.audio       = audio;
  assign bus.audio_valid = audio_valid;
  assign bus.busy        = busy;
  assign bus.clip        = clip;
  assign bus.overrun     = overrun;

endmodule

// File: doc/msx_audio_mixer.md
Name: msx_audio_mixer

Overview:
Parametrised, time-multiplexed audio mixer. It replaces the fixed PSG/keybeep/cassette/cart sum-and-clamp in the MSX top level.
- Snapshots N signed channel inputs on a sample strobe.
- Applies per-channel gain and mute, and accumulates one channel per clock.
- Saturates the result to OUT_W and flags clipping and overruns.
- Sits between the sound sources (PSG, cart sound, keybeep, cassette) and the core audio output.

Parameters:
- CHANNELS, 4, number of input channels (1..16).
- IN_W, 16, signed input sample width.
- GAIN_W, 8, unsigned gain width per channel.
- GAIN_FRAC, 7, gain fractional bits; unity gain = 1<<GAIN_FRAC = 128.
- OUT_W, 16, signed output width (OUT_W <= IN_W+GAIN_W+1).

Ports:
- clk21m, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ce_sample, in, 1, single-cycle sample strobe that starts a mix frame.
- ch_in, in, CHANNELS*IN_W, signed samples; channel k at [k*IN_W +: IN_W].
- ch_gain, in, CHANNELS*GAIN_W, unsigned gains; channel k at [k*GAIN_W +: GAIN_W].
- ch_mute, in, CHANNELS, 1 forces the channel's contribution to 0.
- stat_clr, in, 1, clears the clip and overrun flags.
- audio, out, OUT_W, signed mixed sample, held between frames.
- audio_valid, out, 1, one-cycle pulse when audio updates.
- busy, out, 1, high while a frame is in progress.
- clip, out, 1, sticky: saturation occurred.
- overrun, out, 1, sticky: ce_sample arrived while busy.

Behaviour:
Reset (reset_n low, asynchronous): state=IDLE, acc=0, idx=0, audio=0, audio_valid=0, busy=0, clip=0, overrun=0. Reset mid-frame abandons the frame; no valid pulse is produced.

Widths:
- PROD_W = IN_W+GAIN_W+1 (signed sample x zero-extended gain).
- ACC_W = PROD_W + clog2(CHANNELS) + 1.
- No overflow is possible in acc.

State machine:
- IDLE: on ce_sample, capture ch_in, ch_gain and ch_mute into snapshot registers, clear acc, set idx=0, busy=1, go to ACC. Inputs may change freely after the capture.
- ACC: one channel per clock; acc += mute[idx] ? 0 : $signed(in[idx]) * $signed({1'b0,gain[idx]}).
  - idx increments each cycle.
  - When idx==CHANNELS-1, go to SAT.
- SAT: s = acc >>> GAIN_FRAC (arithmetic shift, truncates toward -inf).
  - If s > 2^(OUT_W-1)-1, audio = 0x7FF..F and clip is set.
  - If s < -2^(OUT_W-1), audio = 0x800..0 and clip is set.
  - Otherwise audio = s[OUT_W-1:0].
  - audio_valid=1 for one cycle, busy=0, go to IDLE.

Latency: ce_sample at cycle 0 → audio_valid at cycle CHANNELS+1, i.e. registered CHANNELS+2 cycles after the strobe edge. Minimum strobe period is CHANNELS+2 clocks.

Boundary conditions:
- ce_sample while busy=1 (including the SAT cycle): ignored; overrun is set; the current frame completes unaffected.
- ce_sample in the cycle after SAT (IDLE again): accepted.
- stat_clr in the same cycle as a new clip or overrun event: set wins.
- CHANNELS=1: ACC lasts exactly one cycle.
- All channels muted: audio=0 with a valid pulse; clip is unchanged.
- Gain 0 behaves identically to mute.

Decomposition:
- MSX package gets mixer_state_t (IDLE, ACC, SAT) and the constant MIX_UNITY_GAIN = 128.
- One natural sub-module, audio_sat: purely combinational, parametrised IN/OUT width. It returns the saturated value plus a clip bit and is reusable for the cart-sound clamp.
- Everything else lives in msx_audio_mixer.

Test Plan:
All scenarios use default parameters.
1. Four channels = 0x1000, gain 128, no mute; ce_sample → audio=0x4000; audio_valid exactly 6 clocks after the strobe; clip=0; busy high for cycles 1..5.
2. Four channels = 0x7FFF, gain 128 → audio=0x7FFF, clip=1. Then stat_clr → clip=0.
3. ch0 = ch1 = 0x8000 (-32768), gain 255, ch2/ch3 muted → audio=0x8000, clip=1.
4. ch0 = 0x2000 with gain 64, ch1..3 = 0x7FFF but muted; ch_in changed to 0 one cycle after the strobe → audio=0x1000 (snapshot honoured).
5. Second ce_sample 2 clocks after the first → exactly one audio_valid, overrun=1. A strobe 7 clocks after the first → accepted with a normal result.
6. reset_n asserted during ACC (cycle 3) → audio=0, busy=0, no valid pulse. After release, a scenario-1 frame gives 0x4000.
